nes_audio_i2s_tx: RTL

Downstream audio stage for the NES SoC top level. It consumes the four signed 16-bit synthesizer channels and the `sample_clk` strobe produced by the SoC. It mixes them into a left/right pair with saturation, double-buffers the result, and serializes it as a standard 16-in-32-bit-slot I2S stream for the board codec. All logic runs on the SoC system clock; BCLK and LRCLK are derived internally by division.

---
 rtl/nes_audio_i2s_tx_if.sv | 43 ++++
 rtl/nes_audio_i2s_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/nes_audio_i2s_tx_if.sv
// nes_audio_i2s_tx_if: channel sample bus in, I2S stream and status flags out.
// master drives samples and enable, slave is the transmitter.
interface nes_audio_i2s_tx_if;
    logic        enable_i;
    logic        sample_clk_i;
    logic [15:0] channel_a_i;
    logic [15:0] channel_b_i;
    logic [15:0] channel_c_i;
    logic [15:0] channel_d_i;
    logic        i2s_bclk_o;
    logic        i2s_lrclk_o;
    logic        i2s_sdata_o;
    logic        overrun_o;
    logic        underrun_o;

    modport master (
        output enable_i,
        output sample_clk_i,
        output channel_a_i,
        output channel_b_i,
        output channel_c_i,
        output channel_d_i,
        input  i2s_bclk_o,
        input  i2s_lrclk_o,
        input  i2s_sdata_o,
        input  overrun_o,
        input  underrun_o
    );

    modport slave (
        input  enable_i,
        input  sample_clk_i,
        input  channel_a_i,
        input  channel_b_i,
        input  channel_c_i,
        input  channel_d_i,
        output i2s_bclk_o,
        output i2s_lrclk_o,
        output i2s_sdata_o,
        output overrun_o,
        output underrun_o
    );
endinterface

// File: rtl/nes_audio_i2s_tx.sv
// nes_audio_i2s_tx: saturating 4-channel mixer, double buffer, 16-in-32 I2S.
// Define NES_AUDIO_STEREO_EN for left=a+b, right=c+d; default is mono.
module nes_audio_i2s_tx #(
    parameter int BCLK_DIV = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    nes_audio_i2s_tx_if.slave bus
);
    localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

    logic          sclk_q;
    logic          smp_rise;
    logic          cap_vld_q;
    logic [15:0]   ca_q;
    logic [15:0]   cb_q;
    logic [15:0]   cc_q;
    logic [15:0]   cd_q;
    logic [15:0]   mix_l;
    logic [15:0]   mix_r;
    logic [15:0]   hold_l_q;
    logic [15:0]   hold_r_q;
    logic          pending_q;
    logic          hold_wr;

    logic [DW-1:0] div_q;
    logic          bclk_q;
    logic [5:0]    bit_cnt_q;
    logic          sdata_q;
    logic [15:0]   frame_l_q;
    logic [15:0]   frame_r_q;
    logic          ovr_q;
    logic          unr_q;

    logic          tick;
    logic          fall;
    logic          load;
    logic [3:0]    bit_idx;
    logic          sdata_nx;

    function automatic logic [15:0] sat17(input logic [16:0] v);
        if (v[16] != v[15])
            return v[16] ? 16'h8000 : 16'h7FFF;
        return v[15:0];
    endfunction

    assign smp_rise = bus.sample_clk_i & ~sclk_q;
    assign hold_wr  = cap_vld_q;

`ifdef NES_AUDIO_STEREO_EN
    logic [16:0] sum_l;
    logic [16:0] sum_r;

    always_comb begin
        sum_l = {ca_q[15], ca_q} + {cb_q[15], cb_q};
        sum_r = {cc_q[15], cc_q} + {cd_q[15], cd_q};
        mix_l = sat17(sum_l);
        mix_r = sat17(sum_r);
    end
`else
    logic [17:0] sum4;

    // sum4[17:1] is the 18-bit sum arithmetically shifted right by one
    always_comb begin
        sum4 = {{2{ca_q[15]}}, ca_q} + {{2{cb_q[15]}}, cb_q}
             + {{2{cc_q[15]}}, cc_q} + {{2{cd_q[15]}}, cd_q};
        mix_l = sat17(sum4[17:1]);
        mix_r = mix_l;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_q    <= 1'b0;
            cap_vld_q <= 1'b0;
            ca_q      <= '0;
            cb_q      <= '0;
            cc_q      <= '0;
            cd_q      <= '0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
        end else begin
            sclk_q    <= bus.sample_clk_i;
            cap_vld_q <= smp_rise;
            if (smp_rise) begin
                ca_q <= bus.channel_a_i;
                cb_q <= bus.channel_b_i;
                cc_q <= bus.channel_c_i;
                cd_q <= bus.channel_d_i;
            end
            if (hold_wr) begin
                hold_l_q <= mix_l;
                hold_r_q <= mix_r;
            end
        end
    end

    assign tick    = bus.enable_i & (div_q == DIV_MAX);
    assign fall    = tick & bclk_q;
    assign load    = fall & (bit_cnt_q == 6'd63);
    assign bit_idx = 4'd15 - bit_cnt_q[3:0];

    // bit_cnt_q is the slot number minus one, so it picks the next bit
    always_comb begin
        sdata_nx = 1'b0;
        unique case (1'b1)
            (bit_cnt_q[5:4] == 2'b00): sdata_nx = frame_l_q[bit_idx];
            (bit_cnt_q[5:4] == 2'b10): sdata_nx = frame_r_q[bit_idx];
            default:                   sdata_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            sdata_q   <= 1'b0;
        end else if (!bus.enable_i) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            sdata_q   <= 1'b0;
        end else begin
            if (tick) begin
                div_q  <= '0;
                bclk_q <= ~bclk_q;
            end else begin
                div_q  <= div_q + DW'(1);
            end
            if (fall) begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
                sdata_q   <= sdata_nx;
            end
        end
    end

    // a write landing on the load cycle keeps pending for the next frame
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_l_q <= '0;
            frame_r_q <= '0;
            pending_q <= 1'b0;
            ovr_q     <= 1'b0;
            unr_q     <= 1'b0;
        end else if (!bus.enable_i) begin
            frame_l_q <= hold_l_q;
            frame_r_q <= hold_r_q;
            pending_q <= 1'b0;
            ovr_q     <= 1'b0;
            unr_q     <= 1'b0;
        end else begin
            if (load) begin
                frame_l_q <= hold_l_q;
                frame_r_q <= hold_r_q;
            end
            if (hold_wr)
                pending_q <= 1'b1;
            else if (load)
                pending_q <= 1'b0;
            ovr_q <= hold_wr & pending_q & ~load;
            unr_q <= load & ~pending_q & ~hold_wr;
        end
    end

    assign bus.i2s_bclk_o  = bclk_q;
    assign bus.i2s_lrclk_o = bit_cnt_q[5];
    assign bus.i2s_sdata_o = sdata_q;
    assign bus.overrun_o   = ovr_q;
    assign bus.underrun_o  = unr_q;
endmodule
